// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    localparam int CNT_W_DEF       = 16;
    localparam int MEM_TIMEOUT_DEF = 255;

    localparam logic [3:0] REG_ZERO = 4'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, hold at all-ones once reached.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-memory stalls, load-use interlock,
// branch flush, fetch stall, halt handling and performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_br_taken,
    input  logic             ex_mem_to_reg,
    input  logic [3:0]       ex_dst,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             wb_hlt,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              dmem_stall;
    logic              br_flush;
    logic              stall_inc;

    assign load_use = ex_mem_to_reg && (ex_dst != REG_ZERO) &&
                      ((id_rs_used && (id_rs == ex_dst)) ||
                       (id_rt_used && (id_rt == ex_dst)));

    // Once in MEM_WAIT the access is outstanding, so only dmem_ready matters.
    assign dmem_stall = ((state == RUN) && dmem_req && !dmem_ready) ||
                        ((state == MEM_WAIT) && !dmem_ready);

    // Prioritised enable/flush decode from state and current inputs.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        halted       = 1'b0;
        br_flush     = 1'b0;
        if (!rst_n) begin
            // defaults: everything enabled while in reset
        end else if (state == HALTED) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            halted    = 1'b1;
        end else if (dmem_stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (state == MEM_WAIT) begin
            // access completing this cycle: release the whole pipeline
        end else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (id_br_taken) begin
            if_id_flush = 1'b1;
            br_flush    = 1'b1;
        end else if (!imem_ready) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    // State, wait counter and sticky memory-error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end else if (wb_hlt) begin
                        state <= HALTED;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        // this cycle is the MEM_TIMEOUT-th unanswered wait cycle
                        if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                            state   <= HALTED;
                            mem_err <= 1'b1;
                        end
                    end
                end
                HALTED: state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    assign stall_inc = (state != HALTED) && !pc_en;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl (CNT_W=4, MEM_TIMEOUT=4).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] id_rs, id_rt, ex_dst;
    logic       id_rs_used, id_rt_used, id_br_taken, ex_mem_to_reg;
    logic       imem_ready, dmem_req, dmem_ready, wb_hlt;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_bubble, halted, mem_err;
    logic [3:0] stall_cnt, flush_cnt;
    logic [6:0] outs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble};

    hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rs_used    (id_rs_used),
        .id_rt_used    (id_rt_used),
        .id_br_taken   (id_br_taken),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_dst        (ex_dst),
        .imem_ready    (imem_ready),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .wb_hlt        (wb_hlt),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .id_ex_en      (id_ex_en),
        .ex_mem_en     (ex_mem_en),
        .mem_wb_en     (mem_wb_en),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .halted        (halted),
        .mem_err       (mem_err),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    typedef struct {
        logic [3:0] rs;
        logic [3:0] rt;
        logic       rs_used;
        logic       rt_used;
        logic       br;
        logic       mtr;
        logic [3:0] dst;
        logic       imem;
        logic       dreq;
        logic       drdy;
        logic [6:0] exp;
        logic       exp_flush;
    } vec_t;

    localparam logic [6:0] ALL_ON  = 7'b1111100;
    localparam logic [6:0] ALL_OFF = 7'b0000000;
    localparam logic [6:0] LDUSE   = 7'b0011101;
    localparam logic [6:0] BRFL    = 7'b1111110;
    localparam logic [6:0] FETCH   = 7'b0111110;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        id_rs = 4'd0; id_rt = 4'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        id_br_taken = 1'b0; ex_mem_to_reg = 1'b0; ex_dst = 4'd0;
        imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0; wb_hlt = 1'b0;
    endtask

    task automatic set_load_use();
        set_idle();
        ex_mem_to_reg = 1'b1; ex_dst = 4'd5; id_rs = 4'd5; id_rs_used = 1'b1;
    endtask

    // Inputs change at posedge+1; checks run at posedge+3.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_idle();
        step();
        step();
        rst_n = 1'b1;
    endtask

    int exp_stall;
    int exp_flush;

    initial begin
        //            rs    rt    rsu   rtu   br    mtr   dst   imem  dreq  drdy  exp     flush
        vecs[0]  = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, ALL_ON, 1'b0};
        vecs[1]  = '{4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, LDUSE,  1'b0};
        vecs[2]  = '{4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, ALL_ON, 1'b0};
        vecs[3]  = '{4'd1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, LDUSE,  1'b0};
        vecs[4]  = '{4'd1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, ALL_ON, 1'b0};
        vecs[5]  = '{4'd9, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, ALL_ON, 1'b0};
        vecs[6]  = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, BRFL,   1'b1};
        vecs[7]  = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, FETCH,  1'b0};
        vecs[8]  = '{4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, LDUSE,  1'b0};
        vecs[9]  = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, ALL_ON, 1'b0};
        vecs[10] = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, BRFL,   1'b1};

        // Reset: outputs fully enabled even with a hazard present.
        rst_n = 1'b0;
        set_load_use();
        step();
        #2;
        chk("reset_outs", 32'(outs), 32'(ALL_ON));
        chk("reset_halted", 32'(halted), 32'd0);
        step();
        rst_n = 1'b1;
        set_idle();
        #2;
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("reset_mem_err", 32'(mem_err), 32'd0);

        // Single-cycle decode table, all in RUN.
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 11; i++) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_rs_used = vecs[i].rs_used; id_rt_used = vecs[i].rt_used;
            id_br_taken = vecs[i].br; ex_mem_to_reg = vecs[i].mtr; ex_dst = vecs[i].dst;
            imem_ready = vecs[i].imem; dmem_req = vecs[i].dreq; dmem_ready = vecs[i].drdy;
            #2;
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_halted", i), 32'(halted), 32'd0);
            if (!vecs[i].exp[6]) exp_stall++;
            if (vecs[i].exp_flush) exp_flush++;
            step();
        end
        set_idle();
        #2;
        chk("table_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        chk("table_flush_cnt", 32'(flush_cnt), 32'(exp_flush));

        // Data-memory wait of three cycles, completes on the fourth.
        do_reset();
        dmem_req = 1'b1;
        dmem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("dmem_wait%0d_outs", c), 32'(outs), 32'(ALL_OFF));
            step();
        end
        dmem_ready = 1'b1;
        #2;
        chk("dmem_done_outs", 32'(outs), 32'(ALL_ON));
        step();
        dmem_req = 1'b0;
        dmem_ready = 1'b0;
        #2;
        chk("dmem_back_run_outs", 32'(outs), 32'(ALL_ON));
        chk("dmem_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("dmem_no_err", 32'(mem_err), 32'd0);

        // Timeout: one RUN stall cycle then four unanswered MEM_WAIT cycles.
        do_reset();
        dmem_req = 1'b1;
        dmem_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #2;
            chk($sformatf("tmo_cycle%0d_halted", c), 32'(halted), 32'd0);
            chk($sformatf("tmo_cycle%0d_outs", c), 32'(outs), 32'(ALL_OFF));
            step();
        end
        #2;
        chk("tmo_mem_err", 32'(mem_err), 32'd1);
        chk("tmo_halted", 32'(halted), 32'd1);
        dmem_ready = 1'b1;
        dmem_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            #2;
            chk($sformatf("tmo_hold%0d_outs", c), 32'(outs), 32'(ALL_OFF));
            chk($sformatf("tmo_hold%0d_halted", c), 32'(halted), 32'd1);
        end
        rst_n = 1'b0;
        set_idle();
        #2;
        chk("tmo_in_reset_outs", 32'(outs), 32'(ALL_ON));
        chk("tmo_in_reset_halted", 32'(halted), 32'd0);
        step();
        rst_n = 1'b1;
        #2;
        chk("tmo_after_reset_err", 32'(mem_err), 32'd0);
        chk("tmo_after_reset_outs", 32'(outs), 32'(ALL_ON));

        // Counter saturation: 20 stall cycles, then 20 flush cycles.
        do_reset();
        set_load_use();
        for (int c = 0; c < 20; c++) step();
        set_idle();
        #2;
        chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
        id_br_taken = 1'b1;
        for (int c = 0; c < 20; c++) step();
        id_br_taken = 1'b0;
        #2;
        chk("sat_flush_cnt", 32'(flush_cnt), 32'd15);

        // Halt from WB: normal decode this cycle, HALTED from the next.
        wb_hlt = 1'b1;
        #2;
        chk("hlt_same_cycle_outs", 32'(outs), 32'(ALL_ON));
        chk("hlt_same_cycle_halted", 32'(halted), 32'd0);
        step();
        wb_hlt = 1'b0;
        #2;
        chk("hlt_halted", 32'(halted), 32'd1);
        chk("hlt_outs", 32'(outs), 32'(ALL_OFF));
        chk("hlt_no_mem_err", 32'(mem_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
